// File: rtl/life_cell_streamer_if.sv
// Cell output stream between the life-cell streamer (master) and its consumer (slave).
// A cell is transferred on every clock where cell_valid and cell_ready are both high.
interface life_cell_streamer_if;
  logic       cell_valid;
  logic       cell_ready;
  logic [2:0] cell_x;
  logic [2:0] cell_y;
  logic       cell_alive;
  logic       cell_born;
  logic       cell_died;

  modport master (
    output cell_valid, cell_x, cell_y, cell_alive, cell_born, cell_died,
    input  cell_ready
  );

  modport slave (
    input  cell_valid, cell_x, cell_y, cell_alive, cell_born, cell_died,
    output cell_ready
  );
endinterface

// File: rtl/life_cell_streamer.sv
// Scans the 64 cells of an 8x8 life array (four 4x4 tiles) and streams each cell with
// alive/born/died flags over a valid/ready register, reporting scan totals on completion.
module life_cell_streamer #(
  parameter bit RASTER = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        busy,
  output logic                        step_inhibit,
  output logic [1:0]                  valo_selector,
  input  logic [15:0]                 valo,
  input  logic [15:0]                 valo_prev,
  life_cell_streamer_if.master        cell_if,
  output logic                        done,
  output logic [6:0]                  alive_count,
  output logic [6:0]                  born_count,
  output logic [6:0]                  died_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nx_s;
  logic [5:0]  cnt_r;
  logic [2:0]  x_s;
  logic [2:0]  y_s;
  logic [1:0]  sel_s;
  logic [3:0]  bit_s;
  logic        load_s;
  logic        clear_s;
  logic        finish_s;
  logic        accept_s;

  logic        busy_r;
  logic        done_r;
  logic        cell_valid_r;
  logic [2:0]  cell_x_r;
  logic [2:0]  cell_y_r;
  logic        cell_alive_r;
  logic        cell_born_r;
  logic        cell_died_r;
  logic [6:0]  run_alive_r;
  logic [6:0]  run_born_r;
  logic [6:0]  run_died_r;
  logic [6:0]  alive_count_r;
  logic [6:0]  born_count_r;
  logic [6:0]  died_count_r;

  assign accept_s = cell_valid_r & cell_if.cell_ready;

  // Counter to coordinate decode; the counter sits at 0 in IDLE so selector 0 serves cell 0 at start.
  always_comb begin
    x_s = 3'd0;
    y_s = 3'd0;
    if (RASTER) begin
      y_s = cnt_r[5:3];
      x_s = cnt_r[2:0];
    end else begin
      x_s = {cnt_r[5], cnt_r[3:2]};
      y_s = {cnt_r[4], cnt_r[1:0]};
    end
    sel_s         = {x_s[2], y_s[2]};
    bit_s         = {x_s[1:0], y_s[1:0]};
    valo_selector = (state_r == ST_SCAN) ? sel_s : 2'd0;
  end

  // Next-state and control strobes.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    clear_s    = 1'b0;
    finish_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s     = 1'b1;
          clear_s    = 1'b1;
          state_nx_s = ST_SCAN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (!cell_valid_r || cell_if.cell_ready) begin
          load_s     = 1'b1;
          state_nx_s = (cnt_r == 6'd63) ? ST_DRAIN : ST_SCAN;
        end else begin
          state_nx_s = ST_SCAN;
        end
      end
      ST_DRAIN: begin
        if (accept_s) begin
          finish_s   = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, busy and done registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != ST_IDLE);
      done_r  <= finish_s;
    end
  end

  // Cell counter and output cell register; holds while a presented cell is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r        <= 6'd0;
      cell_valid_r <= 1'b0;
      cell_x_r     <= 3'd0;
      cell_y_r     <= 3'd0;
      cell_alive_r <= 1'b0;
      cell_born_r  <= 1'b0;
      cell_died_r  <= 1'b0;
    end else if (load_s) begin
      cnt_r        <= cnt_r + 6'd1;
      cell_valid_r <= 1'b1;
      cell_x_r     <= x_s;
      cell_y_r     <= y_s;
      cell_alive_r <= valo[bit_s];
      cell_born_r  <= valo[bit_s] & ~valo_prev[bit_s];
      cell_died_r  <= ~valo[bit_s] & valo_prev[bit_s];
    end else if (accept_s) begin
      cell_valid_r <= 1'b0;
    end else begin
      cell_valid_r <= cell_valid_r;
    end
  end

  // Running totals over accepted cells, published when the last cell is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_alive_r   <= 7'd0;
      run_born_r    <= 7'd0;
      run_died_r    <= 7'd0;
      alive_count_r <= 7'd0;
      born_count_r  <= 7'd0;
      died_count_r  <= 7'd0;
    end else begin
      if (clear_s) begin
        run_alive_r <= 7'd0;
        run_born_r  <= 7'd0;
        run_died_r  <= 7'd0;
      end else if (accept_s) begin
        run_alive_r <= run_alive_r + {6'd0, cell_alive_r};
        run_born_r  <= run_born_r + {6'd0, cell_born_r};
        run_died_r  <= run_died_r + {6'd0, cell_died_r};
      end else begin
        run_alive_r <= run_alive_r;
      end
      if (finish_s) begin
        alive_count_r <= run_alive_r + {6'd0, cell_alive_r};
        born_count_r  <= run_born_r + {6'd0, cell_born_r};
        died_count_r  <= run_died_r + {6'd0, cell_died_r};
      end else begin
        alive_count_r <= alive_count_r;
      end
    end
  end

  assign busy               = busy_r;
  assign step_inhibit       = busy_r;
  assign done               = done_r;
  assign alive_count        = alive_count_r;
  assign born_count         = born_count_r;
  assign died_count         = died_count_r;
  assign cell_if.cell_valid = cell_valid_r;
  assign cell_if.cell_x     = cell_x_r;
  assign cell_if.cell_y     = cell_y_r;
  assign cell_if.cell_alive = cell_alive_r;
  assign cell_if.cell_born  = cell_born_r;
  assign cell_if.cell_died  = cell_died_r;

endmodule

// File: tb/tb_life_cell_streamer.sv
// Drives a raster-order and a tile-order streamer from one modelled 8x8 array and
// scoreboards every transferred cell and every scan total against a reference model.
module tb_life_cell_streamer;
  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
    logic       alive;
    logic       born;
    logic       died;
  } cell_t;

  typedef struct packed {
    logic [6:0] a;
    logic [6:0] b;
    logic [6:0] d;
  } tot_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ready;
  int          ready_mode;
  logic [15:0] tiles [4];
  logic [15:0] prevs [4];

  logic [1:0]  sel   [2];
  logic [15:0] valo  [2];
  logic [15:0] vprev [2];
  logic        busy  [2];
  logic        inh   [2];
  logic        done  [2];
  logic        vld   [2];
  logic [6:0]  ac    [2];
  logic [6:0]  bc    [2];
  logic [6:0]  dc    [2];
  cell_t       got   [2];

  cell_t exp_q [2][$];
  tot_t  tot_q [2][$];
  tot_t  exp_tot  [2];
  tot_t  prev_tot [2];
  cell_t held [2];
  logic  stall_prev [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  life_cell_streamer_if cif0 ();
  life_cell_streamer_if cif1 ();

  assign cif0.cell_ready = ready;
  assign cif1.cell_ready = ready;
  assign vld[0] = cif0.cell_valid;
  assign vld[1] = cif1.cell_valid;
  assign got[0] = {cif0.cell_x, cif0.cell_y, cif0.cell_alive, cif0.cell_born, cif0.cell_died};
  assign got[1] = {cif1.cell_x, cif1.cell_y, cif1.cell_alive, cif1.cell_born, cif1.cell_died};
  assign valo[0]  = tiles[sel[0]];
  assign vprev[0] = prevs[sel[0]];
  assign valo[1]  = tiles[sel[1]];
  assign vprev[1] = prevs[sel[1]];

  life_cell_streamer #(.RASTER(1'b1)) u_raster (
    .clk(clk), .reset(reset), .start(start), .busy(busy[0]), .step_inhibit(inh[0]),
    .valo_selector(sel[0]), .valo(valo[0]), .valo_prev(vprev[0]), .cell_if(cif0),
    .done(done[0]), .alive_count(ac[0]), .born_count(bc[0]), .died_count(dc[0])
  );

  life_cell_streamer #(.RASTER(1'b0)) u_tile (
    .clk(clk), .reset(reset), .start(start), .busy(busy[1]), .step_inhibit(inh[1]),
    .valo_selector(sel[1]), .valo(valo[1]), .valo_prev(vprev[1]), .cell_if(cif1),
    .done(done[1]), .alive_count(ac[1]), .born_count(bc[1]), .died_count(dc[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference: a cell's state straight from the tile mapping of global (x,y).
  function automatic cell_t ref_cell(input int x, input int y);
    cell_t c;
    int    s;
    int    b;
    logic  a;
    logic  p;
    s = (x / 4) * 2 + (y / 4);
    b = (x % 4) * 4 + (y % 4);
    a = tiles[s][b];
    p = prevs[s][b];
    c.x = 3'(x);
    c.y = 3'(y);
    c.alive = a;
    c.born  = a & ~p;
    c.died  = ~a & p;
    return c;
  endfunction

  task automatic push_expect();
    for (int d = 0; d < 2; d++) begin
      tot_t t;
      t = '0;
      for (int i = 0; i < 64; i++) begin
        int    x;
        int    y;
        cell_t c;
        if (d == 0) begin
          y = i / 8;
          x = i % 8;
        end else begin
          x = ((i / 16) / 2) * 4 + (i % 16) / 4;
          y = ((i / 16) % 2) * 4 + (i % 16) % 4;
        end
        c = ref_cell(x, y);
        exp_q[d].push_back(c);
        t.a = t.a + 7'(c.alive);
        t.b = t.b + 7'(c.born);
        t.d = t.d + 7'(c.died);
      end
      tot_q[d].push_back(t);
      exp_tot[d] = t;
    end
  endtask

  task automatic check_idle(input string name);
    for (int d = 0; d < 2; d++) begin
      check({name, "_outputs"}, 32'({vld[d], busy[d], inh[d], done[d], sel[d], got[d]}), 32'd0);
      check({name, "_counts"}, 32'({ac[d], bc[d], dc[d]}), 32'd0);
    end
  endtask

  // Consumer ready pattern: 0 always, 1 alternating, 2 random.
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) ready = ~ready;
      else if (ready_mode == 2) ready = 1'($urandom_range(0, 1));
      else ready = 1'b1;
    end
  end

  // Monitor: compares every transferred cell, stall stability and published totals.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      cell_t e;
      tot_t  t;
      if (reset) begin
        stall_prev[d] <= 1'b0;
      end else begin
        check("busy_vs_inhibit", 32'(inh[d]), 32'(busy[d]));
        if (vld[d] && stall_prev[d]) check("stall_hold", 32'(got[d]), 32'(held[d]));
        if (vld[d] && ready) begin
          check("cell_expected", 32'(exp_q[d].size() != 0), 32'd1);
          if (exp_q[d].size() != 0) begin
            e = exp_q[d].pop_front();
            check("cell", 32'(got[d]), 32'(e));
          end
        end
        stall_prev[d] <= vld[d] & ~ready;
        held[d] <= got[d];
        if (done[d]) begin
          check("cells_left_at_done", 32'(exp_q[d].size()), 32'd0);
          check("done_expected", 32'(tot_q[d].size() != 0), 32'd1);
          if (tot_q[d].size() != 0) begin
            t = tot_q[d].pop_front();
            check("counts", 32'({ac[d], bc[d], dc[d]}), 32'(t));
          end
        end
      end
    end
  end

  task automatic run_scan(input int mode, input bit b2b, input int restart_at,
                          input int reset_at, input int lo, input int hi);
    int cyc;
    bit got_done;
    bit aborted;
    ready_mode = mode;
    if (b2b) begin
      @(negedge clk);
      #1;
    end else begin
      @(posedge clk);
      #1;
    end
    push_expect();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    for (int d = 0; d < 2; d++) check("first_valid_busy", 32'({vld[d], busy[d]}), 32'd3);
    got_done = 1'b0;
    aborted  = 1'b0;
    while (!got_done && !aborted && cyc < 400) begin
      start = (cyc == restart_at);
      if (cyc == reset_at) reset = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        reset = 1'b0;
        start = 1'b0;
        check_idle("abort");
        for (int d = 0; d < 2; d++) begin
          exp_q[d].delete();
          tot_q[d].delete();
          prev_tot[d] = '0;
        end
        aborted = 1'b1;
      end else begin
        if (cyc == 5) begin
          for (int d = 0; d < 2; d++) check("counts_hold", 32'({ac[d], bc[d], dc[d]}), 32'(prev_tot[d]));
        end
        if (done[0]) got_done = 1'b1;
      end
    end
    start = 1'b0;
    if (!aborted) begin
      check("done_seen", 32'(got_done), 32'd1);
      check("done_both", 32'(done[1]), 32'd1);
      checks++;
      if (cyc < lo || cyc > hi) begin
        errors++;
        $display("FAIL done_cycle: got %0d required %0d..%0d", cyc, lo, hi);
      end
      for (int d = 0; d < 2; d++) prev_tot[d] = exp_tot[d];
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    ready_mode = 0;
    for (int s = 0; s < 4; s++) begin
      tiles[s] = 16'h0000;
      prevs[s] = 16'h0000;
    end
    for (int d = 0; d < 2; d++) begin
      prev_tot[d] = '0;
      stall_prev[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    reset = 1'b0;

    // All alive, none before: every cell born.
    for (int s = 0; s < 4; s++) tiles[s] = 16'hFFFF;
    run_scan(0, 1'b0, -1, -1, 65, 65);

    // Single live cell at x=5,y=1, started in the done cycle of the previous scan.
    for (int s = 0; s < 4; s++) tiles[s] = 16'h0000;
    tiles[2] = 16'h0020;
    run_scan(0, 1'b1, -1, -1, 65, 65);

    // Alternating ready.
    for (int s = 0; s < 4; s++) tiles[s] = 16'hFFFF;
    run_scan(1, 1'b0, -1, -1, 127, 129);

    // Start re-pulsed while busy is ignored.
    run_scan(0, 1'b0, 10, -1, 65, 65);

    // Reset mid-scan aborts, then a fresh full scan.
    run_scan(0, 1'b0, -1, 20, 0, 0);
    run_scan(0, 1'b0, -1, -1, 65, 65);

    // Unchanged checkerboard-by-column pattern: alive only, nothing born or died.
    for (int s = 0; s < 4; s++) begin
      tiles[s] = 16'hAAAA;
      prevs[s] = 16'hAAAA;
    end
    run_scan(0, 1'b0, -1, -1, 65, 65);

    // Random arrays with random backpressure.
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 4; s++) begin
        tiles[s] = 16'($urandom);
        prevs[s] = 16'($urandom);
      end
      run_scan(2, (k == 1), -1, -1, 65, 399);
    end

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check("queues_drained", 32'(exp_q[d].size() + tot_q[d].size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/life_cell_streamer.md
LIFE_CELL_STREAMER -- requirements
Module: life_cell_streamer

Interface
REQ-001 Parameter RASTER, default 1; 1 = row-major order (y outer, x inner), 0 = tile order (selector outer, bit index inner).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a 64-cell scan.
REQ-005 busy  output  1  high from start acceptance through last cell accepted.
REQ-006 step_inhibit  output  1  equals busy; upstream SHALL gate the array step with it.
REQ-007 valo_selector  output  2  tile select to the 8x8 array.
REQ-008 valo  input  16  current alive bits of the selected tile (combinational from valo_selector).
REQ-009 valo_prev  input  16  previous-generation bits of the selected tile.
REQ-010 cell_valid  output  1  output cell register holds a cell.
REQ-011 cell_ready  input  1  consumer accepts the cell when cell_valid & cell_ready.
REQ-012 cell_x, cell_y  output  3 each  global cell coordinate, 0..7.
REQ-013 cell_alive, cell_born, cell_died  output  1 each  alive now; alive & !prev; !alive & prev.
REQ-014 done  output  1  one-cycle pulse after the 64th cell is accepted.
REQ-015 alive_count, born_count, died_count  output  7 each  totals for the completed scan, 0..64.

Function
REQ-016 Tile mapping SHALL be: selector = {x[2], y[2]}; bit index = x[1:0]*4 + y[1:0] (tile 0 NW, 1 SW, 2 NE, 3 SE).
REQ-017 States: IDLE, SCAN, DRAIN; IDLE->SCAN on start; SCAN->DRAIN when cell 63 is loaded; DRAIN->IDLE when cell 63 is accepted.
REQ-018 start SHALL be ignored while busy.
REQ-019 A 6-bit cell counter SHALL address cells; in SCAN, valo_selector is decoded from the counter combinationally; valo_selector = 0 outside SCAN.
REQ-020 In SCAN the output register SHALL load the addressed cell and the counter SHALL increment whenever !cell_valid or cell_ready.
REQ-021 First cell_valid SHALL assert the cycle after start is accepted; with cell_ready held high, one cell per cycle, 64 consecutive valid cycles.
REQ-022 When cell_valid & !cell_ready, all cell_* outputs SHALL hold stable and the counter SHALL not advance.
REQ-023 cell_valid SHALL deassert the cycle after cell 63 is accepted unless a new cell is loaded.
REQ-024 Running counters SHALL clear on start acceptance and increment on each accepted cell per its alive/born/died flag; no wrap (max 64 fits 7 bits).
REQ-025 alive_count/born_count/died_count SHALL update together in the cycle done pulses and hold until the next done.
REQ-026 done SHALL pulse in the cycle after cell 63 is accepted; busy falls in that same cycle; a start in the done cycle SHALL be accepted.
REQ-027 RASTER=1 order: counter bits {y,x}; RASTER=0 order: counter bits {selector, bit index} mapped back to x,y per REQ-016.

Reset
REQ-028 On reset: state IDLE, counter 0, valo_selector 0, busy/step_inhibit/cell_valid/done 0, cell_x/cell_y/cell_alive/cell_born/cell_died 0, all counts 0.
REQ-029 Reset asserted mid-scan SHALL abort the scan with no done pulse and no count update.

Verification
REQ-030 All tiles valo=16'hFFFF, prev=0, ready=1, start -> 64 valid cycles, x,y raster 0..7, all born=1, done at cycle 65 after start, alive=64 born=64 died=0.
REQ-031 Only tile 2 bit 5 alive (x=5,y=1), prev empty -> exactly one cell with alive=1 at 14th transfer (index 13), alive_count=1, born_count=1.
REQ-032 ready toggled 1/0 each cycle -> cell outputs stable while stalled, 64 transfers, done after 128 cycles ±1, counts as REQ-030.
REQ-033 start re-pulsed at cycle 10 of a scan -> ignored, exactly 64 cells and one done.
REQ-034 reset asserted at cycle 20 of a scan -> next cycle all outputs per REQ-028, no done; fresh start -> full 64-cell scan.
REQ-035 RASTER=0, valo=prev=16'hAAAA on all tiles -> order by tile then bit, died=0 born=0 alive=32.
